// File: rtl/layer_mac_scheduler.sv
// Fully-connected layer evaluator that time-shares one signed 16x16 MAC across all neurons.
// Each neuron streams out ReLU(sum(act*w) + bias), saturated to 16 bits, one neuron at a time.
module layer_mac_scheduler #(
   parameter int N_INPUTS  = 15,
   parameter int N_NODES   = 8,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 40,
   localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
   localparam int WW = (N_NODES * (N_INPUTS + 1) > 1) ? $clog2(N_NODES * (N_INPUTS + 1)) : 1,
   localparam int IW = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] act_addr,
   input  logic [15:0]   act_data,
   output logic [WW-1:0] w_addr,
   input  logic [15:0]   w_data,
   output logic          out_valid,
   output logic [IW-1:0] out_idx,
   output logic [15:0]   out_data
);

   localparam logic [AW-1:0] K_LAST = AW'(N_INPUTS - 1);
   localparam logic [IW-1:0] J_LAST = IW'(N_NODES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_BIAS,
      S_ACCB,
      S_OUT,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [AW-1:0]            act_addr_q, act_addr_d;
   logic [WW-1:0]            w_addr_q, w_addr_d;
   logic [IW-1:0]            j_q, j_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     out_valid_q, out_valid_d;
   logic [IW-1:0]            out_idx_q, out_idx_d;
   logic [15:0]              out_data_q, out_data_d;
   logic                     prod_vld_q, prod_vld_d;
   logic                     prod_first_q, prod_first_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;

   logic signed [31:0]       prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc_sh;
   logic [15:0]              out_sat;

   // Datapath: data read in cycle t arrives in t+1, so accumulation lags the issue by one cycle.
   always_comb begin
      prod     = $signed(act_data) * $signed(w_data);
      prod_ext = {{(ACC_W-32){prod[31]}}, prod};
      bias_ext = {{(ACC_W-16-FRAC_BITS){w_data[15]}}, w_data, {FRAC_BITS{1'b0}}};
      acc_d    = acc_q;
      if (prod_vld_q) begin
         acc_d = prod_first_q ? prod_ext : acc_q + prod_ext;
      end else if (state_q == S_ACCB) begin
         acc_d = acc_q + bias_ext;
      end
      acc_sh = acc_d >>> FRAC_BITS;
      if (acc_sh[ACC_W-1]) begin
         out_sat = 16'h0000;
      end else if (|acc_sh[ACC_W-2:15]) begin
         out_sat = 16'h7FFF;
      end else begin
         out_sat = acc_sh[15:0];
      end
   end

   // Weight addresses are laid out contiguously, so w_addr only ever increments within a pass.
   always_comb begin
      state_d      = state_q;
      act_addr_d   = act_addr_q;
      w_addr_d     = w_addr_q;
      j_d          = j_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      out_valid_d  = 1'b0;
      out_idx_d    = out_idx_q;
      out_data_d   = out_data_q;
      prod_vld_d   = (state_q == S_MAC);
      prod_first_d = (state_q == S_MAC) && (act_addr_q == '0);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_MAC;
               act_addr_d = '0;
               w_addr_d   = '0;
               j_d        = '0;
               busy_d     = 1'b1;
            end
         end
         S_MAC: begin
            w_addr_d = w_addr_q + 1'b1;
            if (act_addr_q == K_LAST) begin
               state_d = S_BIAS;
            end else begin
               act_addr_d = act_addr_q + 1'b1;
            end
         end
         S_BIAS: begin
            state_d = S_ACCB;
         end
         S_ACCB: begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_idx_d   = j_q;
            out_data_d  = out_sat;
         end
         S_OUT: begin
            if (j_q == J_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d    = S_MAC;
               j_d        = j_q + 1'b1;
               act_addr_d = '0;
               w_addr_d   = w_addr_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         act_addr_q   <= '0;
         w_addr_q     <= '0;
         j_q          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_idx_q    <= '0;
         out_data_q   <= '0;
         prod_vld_q   <= 1'b0;
         prod_first_q <= 1'b0;
         acc_q        <= '0;
      end else begin
         state_q      <= state_d;
         act_addr_q   <= act_addr_d;
         w_addr_q     <= w_addr_d;
         j_q          <= j_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         out_valid_q  <= out_valid_d;
         out_idx_q    <= out_idx_d;
         out_data_q   <= out_data_d;
         prod_vld_q   <= prod_vld_d;
         prod_first_q <= prod_first_d;
         acc_q        <= acc_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign act_addr  = act_addr_q;
   assign w_addr    = w_addr_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Directed bench for layer_mac_scheduler: cycle-exact checks of handshakes, addresses
// and per-neuron results across several activation sets, ignored starts and a mid-pass reset.
module tb_layer_mac_scheduler;

   localparam int NI = 15;
   localparam int NN = 8;
   localparam int P  = NI + 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic [3:0]  act_addr;
   logic [15:0] act_data;
   logic [6:0]  w_addr;
   logic [15:0] w_data;
   logic        out_valid;
   logic [2:0]  out_idx;
   logic [15:0] out_data;

   logic [15:0] act_mem [16];
   logic [15:0] rom [NN*(NI+1)];
   logic [15:0] exp_out [NN];
   logic [15:0] hold_val;
   int          checks = 0;
   int          errors = 0;

   layer_mac_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .act_addr  (act_addr),
      .act_data  (act_data),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   // One-cycle-latency source memories.
   always_ff @(posedge clk) begin
      act_data <= act_mem[act_addr];
      w_data   <= rom[w_addr];
   end

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic set_act(input logic [15:0] v);
      for (int i = 0; i < 16; i++) act_mem[i] = v;
   endtask

   // Caller sits #1 after a rising edge with the DUT idle (or with start already
   // raised in the previous cycle when do_start=0). Walks cycles 0..last_c of a pass.
   task automatic run_pass(input bit do_start, input bit poke, input bit chain, input int last_c);
      int j;
      int p;
      if (do_start) start = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c <= last_c; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         start = (poke && (c == 5 || c == NN*P)) || (chain && c == NN*P + 1);
         j = c / P;
         p = c % P;
         chk("busy", c, busy, c <= NN*P);
         chk("done", c, done, c == NN*P);
         if (j < NN && p == NI + 2) begin
            chk("out_valid", c, out_valid, 1);
            chk("out_idx", c, out_idx, j);
            hold_val = exp_out[j];
         end else begin
            chk("out_valid", c, out_valid, 0);
         end
         chk("out_data", c, out_data, hold_val);
         if (j < NN && p < NI) begin
            chk("act_addr", c, act_addr, p);
            chk("w_addr", c, w_addr, j*(NI+1) + p);
         end else if (j < NN && p == NI) begin
            chk("w_addr_bias", c, w_addr, j*(NI+1) + NI);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      hold_val = 16'h0000;
      set_act(16'h0100);
      for (int k = 0; k < NI; k++) begin
         rom[0*16+k] = 16'h0100;
         rom[1*16+k] = 16'hFF00;
         rom[2*16+k] = 16'h7FFF;
         rom[3*16+k] = 16'h0000;
         rom[4*16+k] = 16'h0080;
         rom[5*16+k] = 16'h0000;
         rom[6*16+k] = 16'h0000;
         rom[7*16+k] = 16'h8000;
      end
      rom[48]  = 16'h0300;
      rom[49]  = 16'hFC00;
      rom[96]  = 16'h0100;
      rom[15]  = 16'h001C;
      rom[31]  = 16'h0000;
      rom[47]  = 16'h7FFF;
      rom[63]  = 16'h0080;
      rom[79]  = 16'hFF80;
      rom[95]  = 16'h0123;
      rom[111] = 16'h0040;
      rom[127] = 16'h7FFF;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", -1, busy, 0);
      chk("rst_done", -1, done, 0);
      chk("rst_out_valid", -1, out_valid, 0);
      chk("rst_out_data", -1, out_data, 0);
      chk("rst_out_idx", -1, out_idx, 0);
      chk("rst_act_addr", -1, act_addr, 0);
      chk("rst_w_addr", -1, w_addr, 0);
      reset = 1'b0;

      // All activations 1.0.
      exp_out = '{16'h0F1C, 16'h0000, 16'h7FFF, 16'h0000, 16'h0700, 16'h0123, 16'h0140, 16'h0000};
      run_pass(1'b1, 1'b0, 1'b0, NN*P + 1);

      // All activations max positive; stray starts at cycles 5 and DONE, fresh start right after.
      set_act(16'h7FFF);
      exp_out = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0123, 16'h7FFF, 16'h0000};
      run_pass(1'b1, 1'b1, 1'b1, NN*P + 1);

      // Sparse mixed-sign case, launched by the start raised in the previous pass's idle cycle.
      set_act(16'h0000);
      act_mem[0] = 16'h0200;
      act_mem[1] = 16'h0100;
      exp_out = '{16'h031C, 16'h0000, 16'h7FFF, 16'h0280, 16'h0100, 16'h0123, 16'h0240, 16'h0000};
      run_pass(1'b0, 1'b0, 1'b0, NN*P + 1);

      // Reset in cycle 40 of a pass, then a clean rerun.
      set_act(16'h0100);
      exp_out = '{16'h0F1C, 16'h0000, 16'h7FFF, 16'h0000, 16'h0700, 16'h0123, 16'h0140, 16'h0000};
      run_pass(1'b1, 1'b0, 1'b0, 40);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy", 41, busy, 0);
      chk("mid_rst_out_valid", 41, out_valid, 0);
      chk("mid_rst_out_data", 41, out_data, 0);
      chk("mid_rst_done", 41, done, 0);
      chk("mid_rst_act_addr", 41, act_addr, 0);
      chk("mid_rst_w_addr", 41, w_addr, 0);
      reset    = 1'b0;
      hold_val = 16'h0000;
      run_pass(1'b1, 1'b0, 1'b0, NN*P + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
